nes_pad_scanner: RTL and testbench
==================================

Name: nes_pad_scanner

Overview:
- Parametrised serial game-pad scanner for NUM_PADS NES-style controllers on one shared latch/pulse bus, with one serial data line per pad.
- Polls every POLL_DIV clocks and shifts in all 8 buttons of every pad.
- Publishes held-button vectors, per-poll new-press flags, the press code of the first new pad-0 press, and a start-press pulse.
- Sits between the board pad connectors and the game logic, and supersedes the single-pad, single-code input controller.

Parameters:
- NUM_PADS, 1, number of controllers sampled in parallel (1..4).
- POLL_DIV, 833333, clocks between scan starts (60 Hz at 50 MHz); must exceed 16*HALF_BIT+2.
- HALF_BIT, 300, clocks per latch half-period and per pulse high or low phase (6 us at 50 MHz).
- CNT_W, 20, width of the poll counter; must satisfy 2^CNT_W > POLL_DIV.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- nes_data  in  NUM_PADS  serial data from each pad; low = pressed; bit p belongs to pad p.
- nes_latch  out  1  latch strobe to all pads.
- nes_pulse  out  1  shift clock to all pads.
- buttons  out  8*NUM_PADS  held state; 1 = pressed; pad p at [8p+7:8p].
- pressed  out  8*NUM_PADS  new presses in the last scan; valid only while scan_done=1.
- scan_done  out  1  one-cycle pulse when buttons/pressed update.
- event_code  out  4  code 1..8 of the lowest-index new press on pad 0; 0 if none; held until the next scan_done.
- start_pulse  out  1  one-cycle pulse with scan_done when pad-0 Start is newly pressed.

Behaviour:
- Button bit order per pad: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right. event_code = bit index + 1.
- Reset (asynchronous, reset_n=0): all outputs 0; poll counter 0; FSM to IDLE; shift registers and previous-state registers cleared.
- Poll counter: counts 0..POLL_DIV-1, then wraps. It runs freely in every state. A wrap starts a scan only in IDLE.
- FSM states and transitions:
  - IDLE: nes_latch=0, nes_pulse=0; go to LATCH on counter wrap.
  - LATCH: nes_latch=1 for 2*HALF_BIT cycles. On the last LATCH cycle, sample bit 0 of every pad as ~nes_data. Then go to LOW with bit index 1; nes_latch drops.
  - LOW: nes_pulse=0 for HALF_BIT cycles, then HIGH.
  - HIGH: nes_pulse=1 for HALF_BIT cycles. On the last HIGH cycle, sample bit[index] of every pad. If index=7, go to DONE; otherwise increment index and go to LOW.
  - DONE: one cycle. nes_pulse=0. Update all published outputs (below), then return to IDLE.
- DONE updates, all in the same cycle:
  - buttons <= sampled vector.
  - pressed <= sampled & ~prev.
  - prev <= sampled.
  - scan_done=1 for this cycle only.
- Total scan length: 16*HALF_BIT+1 cycles from the LATCH entry to the scan_done cycle.
- event_code: priority encoder over pressed[7:0], lowest bit wins. It is registered in DONE and holds until the next DONE, including a 0 result.
- start_pulse = pressed[3] in the DONE cycle.
- A button held across scans produces no new pressed bit. A release clears buttons on the next DONE with no flag.
- Simultaneous new presses: all set in pressed; event_code reports the lowest index only.
- Reset mid-scan: nes_latch and nes_pulse drop asynchronously; no partial data is published.
- Unplugged pad (nes_data floating high): reads as all released.

Optional Feature:
- Macro: NES_DEBOUNCE_EN.
- Defined: a button bit enters the sampled vector only when the raw sample agrees over two consecutive scans. Otherwise the previous accepted value is kept. A press then appears in buttons/pressed one scan later. Adds 8*NUM_PADS raw-history flops.
- Undefined: the raw sample is used directly, as described in Behaviour.

Test Plan (POLL_DIV=100, HALF_BIT=2, NUM_PADS=2):
- Reset then idle, nes_data=2'b11 -> first nes_latch rise at cycle 100 after reset release, high 4 cycles; 7 pulses each 2 high/2 low; scan_done at cycle 133; buttons=0, event_code=0.
- Pad 0 drives low only during the Start slot (bit 3) -> buttons[7:0]=8'h08, pressed[3]=1 and start_pulse=1 with scan_done, event_code=4. On the next scan with the same stimulus: pressed=0, start_pulse=0, buttons unchanged, event_code=0.
- Pad 0 A+Right and pad 1 B pressed in one scan -> buttons=16'h0281, event_code=1.
- Assert reset_n low during the 4th HIGH phase -> nes_pulse=0 immediately; all outputs 0; no scan_done before the next full scan.
- Pad 0 releases all buttons after a held scan -> buttons[7:0]=0, pressed=0, event_code=0 at the next scan_done.
- With NES_DEBOUNCE_EN: Up low for one scan only -> buttons unchanged. Up low for two consecutive scans -> buttons[4]=1 at the second scan_done, event_code=5.

Source files
------------

// File: rtl/nes_pad_scanner.sv
// Serial scanner for NUM_PADS NES pads sharing one latch/pulse bus.
// Optional NES_DEBOUNCE_EN: accept a bit only after two equal scans.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   nes_data[P-1:0]   serial data per pad (low = pressed)
//   nes_latch         latch strobe to all pads
//   nes_pulse         shift clock to all pads
//   buttons[8P-1:0]   held buttons, pad p at [8p+7:8p]
//   pressed[8P-1:0]   new presses of last scan (valid with scan_done)
//   scan_done         one-cycle pulse when buttons/pressed update
//   event_code[3:0]   lowest new pad-0 press (bit+1), 0 if none
//   start_pulse       pad-0 Start newly pressed, with scan_done
module nes_pad_scanner #(
  parameter int NUM_PADS = 1,
  parameter int POLL_DIV = 833333,
  parameter int HALF_BIT = 300,
  parameter int CNT_W    = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_PADS-1:0]   nes_data,
  output logic                  nes_latch,
  output logic                  nes_pulse,
  output logic [8*NUM_PADS-1:0] buttons,
  output logic [8*NUM_PADS-1:0] pressed,
  output logic                  scan_done,
  output logic [3:0]            event_code,
  output logic                  start_pulse
);

  localparam int NB   = 8 * NUM_PADS;
  localparam int PH_W = $clog2(2 * HALF_BIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [2:0]      bit_q, bit_d;
  logic [NB-1:0]   smp_q, smp_d;
  logic [NB-1:0]   btn_q, btn_d;
  logic [NB-1:0]   prs_q, prs_d;
  logic            done_q, done_d;
  logic            start_q, start_d;
  logic [3:0]      code_q, code_d;

  logic [NB-1:0]   acc;
  logic [NB-1:0]   new_prs;
  logic [3:0]      enc;
  logic            wrap;
  logic            last_latch;
  logic            last_half;

  assign wrap       = cnt_q == CNT_W'(POLL_DIV - 1);
  assign last_latch = ph_q == PH_W'(2 * HALF_BIT - 1);
  assign last_half  = ph_q == PH_W'(HALF_BIT - 1);

`ifdef NES_DEBOUNCE_EN
  logic [NB-1:0] hist_q, hist_d;
  logic [NB-1:0] agree;

  // Bits whose raw sample matches the previous scan are accepted;
  // the rest keep their last accepted value.
  assign agree = ~(smp_q ^ hist_q);
  assign acc   = (smp_q & agree) | (btn_q & ~agree);

  always_comb begin
    hist_d = hist_q;
    if (state_q == S_DONE) hist_d = smp_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= '0;
    else          hist_q <= hist_d;
  end
`else
  assign acc = smp_q;
`endif

  // buttons_q doubles as the previous accepted vector
  assign new_prs = acc & ~btn_q;

  // Lowest-index new press on pad 0 wins
  always_comb begin
    enc = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (new_prs[i]) enc = 4'(i + 1);
    end
  end

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    btn_d   = btn_q;
    prs_d   = prs_q;
    code_d  = code_q;
    done_d  = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (wrap) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (last_latch) begin
          for (int p = 0; p < NUM_PADS; p++)
            smp_d[8*p] = ~nes_data[p];
          bit_d   = 3'd1;
          ph_d    = '0;
          state_d = S_LOW;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_LOW: begin
        if (last_half) begin
          ph_d    = '0;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_HIGH: begin
        if (last_half) begin
          for (int p = 0; p < NUM_PADS; p++)
            smp_d[8*p + int'(bit_q)] = ~nes_data[p];
          ph_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_LOW;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_DONE: begin
        btn_d   = acc;
        prs_d   = new_prs;
        code_d  = enc;
        done_d  = 1'b1;
        start_d = new_prs[3];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      btn_q   <= '0;
      prs_q   <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      btn_q   <= btn_d;
      prs_q   <= prs_d;
      code_q  <= code_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  // Decoded from state so both strobes drop with the async reset
  assign nes_latch   = state_q == S_LATCH;
  assign nes_pulse   = state_q == S_HIGH;
  assign buttons     = btn_q;
  assign pressed     = prs_q;
  assign scan_done   = done_q;
  assign event_code  = code_q;
  assign start_pulse = start_q;

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Directed bench for nes_pad_scanner with two modelled pads.
// POLL_DIV=100, HALF_BIT=2, NUM_PADS=2, default build.
module tb_nes_pad_scanner;

  logic        clk;
  logic        reset_n;
  logic [1:0]  nes_data;
  logic        nes_latch;
  logic        nes_pulse;
  logic [15:0] buttons;
  logic [15:0] pressed;
  logic        scan_done;
  logic [3:0]  event_code;
  logic        start_pulse;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] pad_btn [2];
  int         idx = 8;

  nes_pad_scanner #(
    .NUM_PADS(2),
    .POLL_DIV(100),
    .HALF_BIT(2),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .nes_data(nes_data),
    .nes_latch(nes_latch),
    .nes_pulse(nes_pulse),
    .buttons(buttons),
    .pressed(pressed),
    .scan_done(scan_done),
    .event_code(event_code),
    .start_pulse(start_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: latch loads bit 0, each pulse rise shifts to the next
  always @(posedge nes_latch) idx = 0;
  always @(posedge nes_pulse) idx = idx + 1;

  always @* begin
    for (int p = 0; p < 2; p++)
      nes_data[p] = (idx < 8) ? ~pad_btn[p][idx[2:0]] : 1'b1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!scan_done && k < 250);
    check({tag, "_done"}, {31'd0, scan_done}, 32'd1);
  endtask

  initial begin
    int lat_err, pul_err, sd_err, rises, done_at;
    logic pp;

    pad_btn[0] = 8'h00;
    pad_btn[1] = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_latch", {31'd0, nes_latch}, 32'd0);
    check("rst_pulse", {31'd0, nes_pulse}, 32'd0);
    check("rst_out", {buttons, pressed}, 32'd0);
    check("rst_misc", {26'd0, scan_done, start_pulse, event_code}, 32'd0);

    // First scan: cycle-accurate strobe trace
    reset_n = 1'b1;
    lat_err = 0; pul_err = 0; sd_err = 0; rises = 0;
    done_at = 0; pp = 1'b0;
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (nes_latch !== (n >= 100 && n <= 103)) lat_err++;
      if (nes_pulse !== (n >= 104 && n <= 131 && ((n - 104) % 4) >= 2))
        pul_err++;
      if (scan_done !== (n == 133)) sd_err++;
      if (nes_pulse && !pp) rises++;
      pp = nes_pulse;
      if (scan_done) begin
        done_at = n;
        check("s1_buttons", {16'd0, buttons}, 32'h0);
        check("s1_code", {28'd0, event_code}, 32'd0);
      end
    end
    check("s1_latch_trace", lat_err, 0);
    check("s1_pulse_trace", pul_err, 0);
    check("s1_done_trace", sd_err, 0);
    check("s1_done_cycle", done_at, 133);
    check("s1_pulse_count", rises, 7);

    // Start pressed on pad 0
    pad_btn[0] = 8'h08;
    wait_done("s2");
    check("s2_buttons", {16'd0, buttons}, 32'h0008);
    check("s2_pressed", {16'd0, pressed}, 32'h0008);
    check("s2_start", {31'd0, start_pulse}, 32'd1);
    check("s2_code", {28'd0, event_code}, 32'd4);

    // Start held
    wait_done("s3");
    check("s3_buttons", {16'd0, buttons}, 32'h0008);
    check("s3_pressed", {16'd0, pressed}, 32'h0000);
    check("s3_start", {31'd0, start_pulse}, 32'd0);
    check("s3_code", {28'd0, event_code}, 32'd0);

    // Pad 0 A+Right, pad 1 B
    pad_btn[0] = 8'h81;
    pad_btn[1] = 8'h02;
    wait_done("s4");
    check("s4_buttons", {16'd0, buttons}, 32'h0281);
    check("s4_pressed", {16'd0, pressed}, 32'h0281);
    check("s4_code", {28'd0, event_code}, 32'd1);
    check("s4_start", {31'd0, start_pulse}, 32'd0);
    @(negedge clk);
    check("s4_code_hold", {28'd0, event_code}, 32'd1);
    check("s4_done_pulse", {31'd0, scan_done}, 32'd0);

    // Pad 0 releases everything
    pad_btn[0] = 8'h00;
    wait_done("s5");
    check("s5_buttons", {16'd0, buttons}, 32'h0200);
    check("s5_pressed", {16'd0, pressed}, 32'h0000);
    check("s5_code", {28'd0, event_code}, 32'd0);

    // Reset during the 4th HIGH phase
    rises = 0; pp = 1'b0;
    for (int k = 0; k < 300 && rises < 4; k++) begin
      @(negedge clk);
      if (nes_pulse && !pp) rises++;
      pp = nes_pulse;
    end
    check("s6_found_high4", rises, 4);
    #2 reset_n = 1'b0;
    #1;
    check("s6_pulse_async", {31'd0, nes_pulse}, 32'd0);
    check("s6_latch_async", {31'd0, nes_latch}, 32'd0);
    check("s6_out_async", {buttons, pressed}, 32'd0);
    check("s6_misc_async", {26'd0, scan_done, start_pulse, event_code},
          32'd0);
    pad_btn[0] = 8'h10;
    pad_btn[1] = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    sd_err = 0; done_at = 0;
    for (int n = 1; n <= 133; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (scan_done && n < 133) sd_err++;
      if (scan_done && n == 133) done_at = n;
    end
    check("s6_no_early_done", sd_err, 0);
    check("s6_done_cycle", done_at, 133);
    check("s6_buttons", {16'd0, buttons}, 32'h0010);
    check("s6_pressed", {16'd0, pressed}, 32'h0010);
    check("s6_code", {28'd0, event_code}, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
